// File: rtl/dsr_pkg.sv
// Shared types and defaults for the DSR job scheduler.
// Holds the FSM state encoding, the abort result code and parameter defaults.
package dsr_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [7:0] ERR_CODE = 8'hEE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/dsr_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, with wrap.
// Ports: req, rr_ptr in; one-hot grant and its binary idx out (zero when no req).
module dsr_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One spare bit so rr_ptr + k cannot overflow before the wrap.
            pos = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N_REQ))
                pos = pos - (IW + 1)'(N_REQ);
            if (!found && req[pos[IW-1:0]]) begin
                found                = 1'b1;
                grant[pos[IW-1:0]]   = 1'b1;
                idx                  = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dsr_sched.sv
// Shares one DSR engine between N_REQ requesters with round-robin grant and timeout abort.
// Ports: req/req_data in, ack/resp_data/resp_err/busy out, eng_* engine handshake.
module dsr_sched
    import dsr_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]  ack,
    output logic [DW-1:0]     resp_data,
    output logic              resp_err,
    output logic              busy,
    output logic              eng_start,
    output logic [DW-1:0]     eng_data,
    input  logic [DW-1:0]     eng_result,
    input  logic              eng_done,
    output logic              eng_flush
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]   gnt_idx;
    logic [DW-1:0]   op_sel;
    logic [IW-1:0]   ptr_nxt;

    dsr_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (gnt_idx)
    );

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i])
                op_sel = req_data[i*DW +: DW];
    end

    assign ptr_nxt = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
    assign busy    = (state != IDLE);

    // eng_data doubles as the latched operand: loaded on grant, held
    // through ISSUE/BUSY, cleared when the job leaves BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            idx_q     <= '0;
            cnt       <= '0;
            ack       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            eng_start <= 1'b0;
            eng_data  <= '0;
            eng_flush <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_flush <= 1'b0;
            ack       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        idx_q     <= gnt_idx;
                        eng_data  <= op_sel;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    // Done takes priority over a coincident timeout.
                    if (eng_done) begin
                        resp_data <= eng_result;
                        ack       <= N_REQ'(1) << idx_q;
                        eng_data  <= '0;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_data <= DW'(ERR_CODE);
                        resp_err  <= 1'b1;
                        eng_flush <= 1'b1;
                        ack       <= N_REQ'(1) << idx_q;
                        eng_data  <= '0;
                        state     <= ABORT;
                    end
                end
                RESP, ABORT: begin
                    rr_ptr <= ptr_nxt;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dsr_sched.md
DSR_SCHED -- requirements
Module: dsr_sched

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters sharing one DSR processing engine (2..8).
REQ-002 Parameter DW, default 8, meaning data/result width.
REQ-003 Parameter TIMEOUT, default 64, meaning max engine cycles per job before abort (>=4).
REQ-004 Port clk, input, 1, meaning single clock; all logic rising-edge.
REQ-005 Port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 Port req, input, N_REQ, meaning per-requester job request (level, held until ack).
REQ-007 Port req_data, input, N_REQ*DW, meaning per-requester operand, slice i = bits [i*DW +: DW].
REQ-008 Port ack, output, N_REQ, meaning one-cycle completion pulse to the granted requester.
REQ-009 Port resp_data, output, DW, meaning job result, valid only while any ack bit is 1.
REQ-010 Port resp_err, output, 1, meaning job aborted by timeout, valid with ack.
REQ-011 Port busy, output, 1, meaning a job is in flight (state != IDLE).
REQ-012 Port eng_start, output, 1, meaning one-cycle start pulse to engine.
REQ-013 Port eng_data, output, DW, meaning operand driven to engine.
REQ-014 Port eng_result, input, DW, meaning engine output data.
REQ-015 Port eng_done, input, 1, meaning engine completion flag.
REQ-016 Port eng_flush, output, 1, meaning one-cycle engine abort/flush pulse.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, BUSY, RESP, ABORT; encoding 3 bits, IDLE = 0.
REQ-018 IDLE: if any req bit set, SHALL grant the first set bit searching upward from rr_ptr with wrap, latch index and req_data slice, go ISSUE; else stay.
REQ-019 ISSUE: eng_start=1 and eng_data=latched operand for exactly one cycle; clear cycle counter; go BUSY.
REQ-020 BUSY: eng_data SHALL hold latched operand; counter increments each cycle; eng_done sampled only in BUSY.
REQ-021 BUSY with eng_done=1: capture eng_result, go RESP.
REQ-022 BUSY with counter == TIMEOUT-1 and eng_done=0: go ABORT.
REQ-023 eng_done and timeout in same cycle: done SHALL win (go RESP).
REQ-024 RESP: ack[idx]=1, resp_data=captured result, resp_err=0 for one cycle; go IDLE.
REQ-025 ABORT: eng_flush=1, ack[idx]=1, resp_data=8'hEE (zero-extended to DW), resp_err=1 for one cycle; go IDLE.
REQ-026 On leaving RESP or ABORT, rr_ptr SHALL become (idx+1) mod N_REQ.
REQ-027 A requester dropping req after grant SHALL NOT cancel the job; ack still issued.
REQ-028 req changes on non-granted lines during a job SHALL be ignored until return to IDLE.
REQ-029 Outside their states, eng_start, eng_flush, ack, resp_err SHALL be 0; resp_data and eng_data 0 when not valid/held.
REQ-030 Minimum latency req->ack: 4 cycles (IDLE, ISSUE, BUSY with done, RESP); back-to-back grants possible every job+1 cycle.

Reset
REQ-031 rst=1 SHALL force state IDLE, rr_ptr=0, counter=0, latched index/operand/result=0, all outputs 0, asynchronously.
REQ-032 Reset mid-job SHALL drop the job without ack or eng_flush; requester re-arbitrates after release.

Structure
REQ-033 Package dsr_pkg SHALL hold the state enum, ERR_CODE=8'hEE and default parameter values.
REQ-034 Round-robin priority pick SHALL be a sub-module dsr_rr_arbiter (combinational, inputs req and rr_ptr, outputs one-hot grant and index).

Verification
REQ-035 Single req[0], data 8'h0B, engine done after 3 BUSY cycles with result 8'h17 -> ack[0] one cycle, resp_data 8'h17, resp_err 0.
REQ-036 req=4'b1111 held, engine always done -> grants in order 0,1,2,3,0 (fairness, wrap of rr_ptr).
REQ-037 Engine never done -> after TIMEOUT cycles in BUSY: eng_flush pulse, ack with resp_data 8'hEE, resp_err 1.
REQ-038 eng_done asserted exactly on cycle TIMEOUT-1 -> RESP with result, no eng_flush.
REQ-039 rst asserted during BUSY -> all outputs 0 immediately, no ack; after release, pending req re-granted starting from index 0.
REQ-040 Granted requester drops req one cycle after grant -> job completes, ack still delivered.
